reg_dump_ctrl: RTL and testbench

- Reader side of the register-file observe port (`observe` index out, `data_ob` word back).
- On a start pulse, walks a range of register indices, snapshots each 32-bit value and streams it out as bytes over a valid/ready byte interface.
- Sits beside `Registers` in the single-cycle MIPS top; its byte stream feeds a UART/console transmitter for post-run register dumps, replacing bench-side $display polling.

---
 rtl/dump_pkg.sv | 30 +++
 rtl/byte_serializer.sv | 65 ++++++
 rtl/reg_dump_ctrl.sv | 96 +++++++++
 tb/tb_reg_dump_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dump_pkg.sv
// ============================================================================
// Module  : dump_pkg
// Brief   : Shared FSM encoding and sizing helpers for the register dumper.
// Revision: 1.0
// ============================================================================
`default_nettype none

package dump_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SELECT = 2'd1;
  localparam logic [1:0] ST_SEND   = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_SELECT = ST_SELECT,
    S_SEND   = ST_SEND,
    S_DONE   = ST_DONE
  } state_t;

  localparam logic [2:0] HDR_PAD = 3'b000;

  function automatic int bytes_per_reg(input int data_w, input int header_en);
    return data_w / 8 + header_en;
  endfunction

endpackage

`default_nettype wire

// File: rtl/byte_serializer.sv
// ============================================================================
// Module  : byte_serializer
// Brief   : Loads an optional header plus a word, emits bytes MSB first.
// Revision: 1.0
// ============================================================================
`default_nettype none

module byte_serializer
  import dump_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter bit HEADER_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [7:0]        hdr,
  input  logic [DATA_W-1:0] word,
  input  logic              tx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  output logic              last_byte
);

  localparam int NB    = bytes_per_reg(DATA_W, int'(HEADER_EN));
  localparam int CNT_W = $clog2(NB + 1);

  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_shift;
  logic              w_xfer;

  assign w_xfer    = tx_valid && tx_ready;
  assign last_byte = w_xfer && (r_cnt == CNT_W'(NB - 1));

  // r_shift holds the data bytes not yet presented, top byte next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_shift  <= '0;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
    end else if (load) begin
      r_cnt    <= '0;
      tx_valid <= 1'b1;
      if (HEADER_EN) begin
        tx_data <= hdr;
        r_shift <= word;
      end else begin
        tx_data <= word[DATA_W-1 -: 8];
        r_shift <= word << 8;
      end
    end else if (w_xfer) begin
      if (last_byte) begin
        tx_valid <= 1'b0;
      end else begin
        r_cnt   <= r_cnt + CNT_W'(1);
        tx_data <= r_shift[DATA_W-1 -: 8];
        r_shift <= r_shift << 8;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/reg_dump_ctrl.sv
// ============================================================================
// Module  : reg_dump_ctrl
// Brief   : Walks a register index range and streams each value as bytes.
// Revision: 1.0
// ============================================================================
`default_nettype none

module reg_dump_ctrl
  import dump_pkg::*;
#(
  parameter bit HEADER_EN = 1'b1,
  parameter int DATA_W    = 32
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              start,
  input  logic [4:0]        first_reg,
  input  logic [4:0]        last_reg,
  output logic [4:0]        observe,
  input  logic [DATA_W-1:0] data_ob,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  state_t     r_state;
  logic [4:0] r_last;
  logic       w_load;
  logic       w_last_byte;
  logic [7:0] w_hdr;

  assign w_load = (r_state == S_SELECT);
  assign w_hdr  = {HDR_PAD, observe};

  byte_serializer #(
    .DATA_W    (DATA_W),
    .HEADER_EN (HEADER_EN)
  ) u_ser (
    .clk       (CLK),
    .rst_n     (reset),
    .load      (w_load),
    .hdr       (w_hdr),
    .word      (data_ob),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .last_byte (w_last_byte)
  );

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_last  <= 5'd0;
      observe <= 5'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_last  <= last_reg;
            observe <= first_reg;
            busy    <= 1'b1;
            r_state <= S_SELECT;
          end
        end
        S_SELECT: begin
          r_state <= S_SEND;
        end
        S_SEND: begin
          if (w_last_byte) begin
            if (observe == r_last) begin
              done    <= 1'b1;
              r_state <= S_DONE;
            end else begin
              // 5-bit add wraps 31 -> 0 so descending ranges pass through zero.
              observe <= observe + 5'd1;
              r_state <= S_SELECT;
            end
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reg_dump_ctrl.sv
// ============================================================================
// Module  : tb_reg_dump_ctrl
// Brief   : Scoreboard bench for reg_dump_ctrl, header and headerless builds.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_reg_dump_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] regs [32];

  logic        start_h, start_n, rdy_h, rdy_n;
  logic [4:0]  first_h, last_h, first_n, last_n, obs_h, obs_n;
  logic [31:0] data_h, data_n;
  logic [7:0]  txd_h, txd_n;
  logic        txv_h, txv_n, busy_h, busy_n, done_h, done_n;

  assign data_h = (obs_h == 5'd0) ? 32'h0 : regs[obs_h];
  assign data_n = (obs_n == 5'd0) ? 32'h0 : regs[obs_n];

  reg_dump_ctrl #(.HEADER_EN(1'b1), .DATA_W(32)) u_dut_h (
    .CLK(clk), .reset(rst_n), .start(start_h), .first_reg(first_h),
    .last_reg(last_h), .observe(obs_h), .data_ob(data_h), .tx_data(txd_h),
    .tx_valid(txv_h), .tx_ready(rdy_h), .busy(busy_h), .done(done_h));

  reg_dump_ctrl #(.HEADER_EN(1'b0), .DATA_W(32)) u_dut_n (
    .CLK(clk), .reset(rst_n), .start(start_n), .first_reg(first_n),
    .last_reg(last_n), .observe(obs_n), .data_ob(data_n), .tx_data(txd_n),
    .tx_valid(txv_n), .tx_ready(rdy_n), .busy(busy_n), .done(done_n));

  typedef struct packed {
    logic [4:0] idx;
    logic [7:0] b;
  } exp_t;

  exp_t q_h[$];
  exp_t q_n[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   dcnt_h      = 0;
  int   dcnt_n      = 0;
  int   mode_h      = 0;  // 0: ready high, 1: toggle, 2: ready low

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_reg(input bit hdr_dut, input logic [4:0] i);
    logic [31:0] w;
    w = (i == 5'd0) ? 32'h0 : regs[i];
    if (hdr_dut) q_h.push_back({i, {3'b000, i}});
    for (int k = 3; k >= 0; k--) begin
      if (hdr_dut) q_h.push_back({i, w[8*k +: 8]});
      else         q_n.push_back({i, w[8*k +: 8]});
    end
  endtask

  // Monitors: pop expected byte and index on every handshake.
  logic [7:0] hold_h;
  logic       stall_h = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (stall_h) begin
        check("hold_valid_h", 32'(txv_h), 32'd1);
        check("hold_data_h", 32'(txd_h), 32'(hold_h));
      end
      if (txv_h && rdy_h) begin
        if (q_h.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL extra_byte_h: got 0x%0h expected none", txd_h);
        end else begin
          e = q_h.pop_front();
          check("byte_h", 32'(txd_h), 32'(e.b));
          check("observe_h", 32'(obs_h), 32'(e.idx));
        end
      end
      stall_h = txv_h && !rdy_h;
      hold_h  = txd_h;
      if (done_h) dcnt_h++;
    end else begin
      stall_h = 1'b0;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (txv_n && rdy_n) begin
        if (q_n.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL extra_byte_n: got 0x%0h expected none", txd_n);
        end else begin
          e = q_n.pop_front();
          check("byte_n", 32'(txd_n), 32'(e.b));
          check("observe_n", 32'(obs_n), 32'(e.idx));
        end
      end
      if (done_n) dcnt_n++;
    end
  end

  initial begin
    rdy_h = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (mode_h)
        1:       rdy_h = ~rdy_h;
        2:       rdy_h = 1'b0;
        default: rdy_h = 1'b1;
      endcase
    end
  end

  task automatic run_start(input bit hdr_dut, input logic [4:0] f, input logic [4:0] l);
    @(posedge clk);
    #1;
    if (hdr_dut) begin first_h = f; last_h = l; start_h = 1'b1; end
    else         begin first_n = f; last_n = l; start_n = 1'b1; end
    @(posedge clk);
    #1;
    start_h = 1'b0;
    start_n = 1'b0;
  endtask

  task automatic wait_done(input bit hdr_dut, input string name);
    int  n;
    bit  seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 600) begin
      @(posedge clk);
      #2;
      n++;
      seen = hdr_dut ? done_h : done_n;
    end
    check({name, "_done_seen"}, 32'(seen), 32'd1);
    check({name, "_bytes_left"}, 32'(hdr_dut ? q_h.size() : q_n.size()), 32'd0);
  endtask

  initial begin
    int n;
    int d0;
    rst_n   = 1'b0;
    start_h = 1'b0; start_n = 1'b0;
    first_h = 5'd0; last_h  = 5'd0;
    first_n = 5'd0; last_n  = 5'd0;
    rdy_n   = 1'b1;
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    regs[0] = 32'hFFFF_FFFF;  // register-file port must still read 0 for index 0

    repeat (3) @(posedge clk);
    #2;
    check("rst_observe_h", 32'(obs_h), 32'd0);
    check("rst_valid_h", 32'(txv_h), 32'd0);
    check("rst_data_h", 32'(txd_h), 32'd0);
    check("rst_busy_h", 32'(busy_h), 32'd0);
    check("rst_done_n", 32'(done_n), 32'd0);
    check("rst_valid_n", 32'(txv_n), 32'd0);
    rst_n = 1'b1;

    // Single register with header, ready high
    regs[16] = 32'h1234_5678;
    mode_h   = 0;
    q_h.push_back({5'd16, 8'h10});
    q_h.push_back({5'd16, 8'h12});
    q_h.push_back({5'd16, 8'h34});
    q_h.push_back({5'd16, 8'h56});
    q_h.push_back({5'd16, 8'h78});
    d0 = dcnt_h;
    run_start(1'b1, 5'd16, 5'd16);
    check("select_valid", 32'(txv_h), 32'd0);
    check("select_busy", 32'(busy_h), 32'd1);
    check("select_observe", 32'(obs_h), 32'd16);
    @(posedge clk);
    #1;
    check("latency_valid", 32'(txv_h), 32'd1);
    n = 0;
    while (txv_h && n < 20) begin
      n++;
      @(posedge clk);
      #1;
    end
    check("burst_len", 32'(n), 32'd5);
    check("done_pulse", 32'(done_h), 32'd1);
    check("busy_at_done", 32'(busy_h), 32'd1);
    @(posedge clk);
    #1;
    check("done_cleared", 32'(done_h), 32'd0);
    check("busy_cleared", 32'(busy_h), 32'd0);
    check("single_bytes_left", 32'(q_h.size()), 32'd0);
    check("single_done_count", 32'(dcnt_h - d0), 32'd1);

    // Range 16..18 with toggling ready
    regs[16] = 32'hAAAA_0001;
    regs[17] = 32'hBBBB_0002;
    regs[18] = 32'hCCCC_0003;
    mode_h   = 1;
    for (int i = 16; i <= 18; i++) push_reg(1'b1, 5'(i));
    run_start(1'b1, 5'd16, 5'd18);
    wait_done(1'b1, "range");
    mode_h = 0;

    // Wrap 30 -> 1 on the headerless build
    regs[30] = 32'h1122_3344;
    regs[31] = 32'h5566_7788;
    regs[1]  = 32'h99AA_BBCC;
    push_reg(1'b0, 5'd30);
    push_reg(1'b0, 5'd31);
    for (int k = 0; k < 4; k++) q_n.push_back({5'd0, 8'h00});
    push_reg(1'b0, 5'd1);
    check("wrap_queue_len", 32'(q_n.size()), 32'd16);
    run_start(1'b0, 5'd30, 5'd1);
    wait_done(1'b0, "wrap");

    // Start while busy is ignored
    d0 = dcnt_h;
    for (int i = 16; i <= 18; i++) push_reg(1'b1, 5'(i));
    run_start(1'b1, 5'd16, 5'd18);
    repeat (4) @(posedge clk);
    #1;
    first_h = 5'd5; last_h = 5'd5; start_h = 1'b1;
    @(posedge clk);
    #1;
    start_h = 1'b0;
    wait_done(1'b1, "busy_start");
    repeat (10) @(posedge clk);
    #1;
    check("busy_start_idle", 32'(busy_h), 32'd0);
    check("busy_start_valid", 32'(txv_h), 32'd0);
    check("busy_start_dones", 32'(dcnt_h - d0), 32'd1);

    // Snapshot: write after capture must not affect bytes in flight
    regs[17] = 32'h0102_0304;
    push_reg(1'b1, 5'd17);
    run_start(1'b1, 5'd17, 5'd17);
    @(posedge clk);
    #1;
    regs[17] = 32'hDEAD_BEEF;
    wait_done(1'b1, "snap_old");
    q_h.push_back({5'd17, 8'h11});
    q_h.push_back({5'd17, 8'hDE});
    q_h.push_back({5'd17, 8'hAD});
    q_h.push_back({5'd17, 8'hBE});
    q_h.push_back({5'd17, 8'hEF});
    run_start(1'b1, 5'd17, 5'd17);
    wait_done(1'b1, "snap_new");

    // Asynchronous reset in the middle of a stalled byte
    mode_h = 2;
    run_start(1'b1, 5'd16, 5'd16);
    n = 0;
    while (!txv_h && n < 20) begin
      n++;
      @(posedge clk);
      #1;
    end
    check("stall_valid", 32'(txv_h), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("areset_valid", 32'(txv_h), 32'd0);
    check("areset_busy", 32'(busy_h), 32'd0);
    check("areset_observe", 32'(obs_h), 32'd0);
    check("areset_data", 32'(txd_h), 32'd0);
    q_h.delete();
    #7;
    rst_n  = 1'b1;
    mode_h = 0;
    push_reg(1'b1, 5'd18);
    run_start(1'b1, 5'd18, 5'd18);
    wait_done(1'b1, "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
